// File: rtl/mem_arbiter.sv
// Shared memory-port arbiter: fetch, data-read and data-write requesters take
// turns on one port, write > read > fetch, with fetch anti-starvation and an access timeout.
module mem_arbiter #(
  parameter int WIDTH        = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] ia,
  input  logic             ia_enable,
  output logic [WIDTH-1:0] iv,
  output logic             iv_valid,
  input  logic [WIDTH-1:0] da_in,
  input  logic             da_in_enable,
  output logic [WIDTH-1:0] dv_in,
  output logic             dv_in_valid,
  input  logic [WIDTH-1:0] da_out,
  input  logic             da_out_enable,
  input  logic [WIDTH-1:0] dv_out,
  output logic             dv_out_valid,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_read,
  output logic             mem_write,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic             mem_ack,
  output logic [2:0]       grant,
  output logic             bus_error
);

  localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  // The wait counter only has to reach TIMEOUT-1: the TIMEOUT-th cycle decides.
  localparam int WW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [WW-1:0] WAIT_LAST  = WW'(TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCESS  = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  localparam logic [2:0] GNT_NONE  = 3'b000;
  localparam logic [2:0] GNT_FETCH = 3'b001;
  localparam logic [2:0] GNT_READ  = 3'b010;
  localparam logic [2:0] GNT_WRITE = 3'b100;

  logic [1:0]       state_r;
  logic [SW-1:0]    starve_r;
  logic [SW-1:0]    starve_nxt_s;
  logic [WW-1:0]    wait_r;
  logic [2:0]       win_s;
  logic [WIDTH-1:0] win_addr_s;
  logic             ack_s;
  logic             expire_s;
  logic             done_s;
  logic [WIDTH-1:0] rdata_s;

  // Arbitration winner among the current enables.
  always_comb begin
    win_s      = GNT_NONE;
    win_addr_s = {WIDTH{1'b0}};
    if (ia_enable && (starve_r == STARVE_MAX)) begin
      win_s      = GNT_FETCH;
      win_addr_s = ia;
    end else if (da_out_enable) begin
      win_s      = GNT_WRITE;
      win_addr_s = da_out;
    end else if (da_in_enable) begin
      win_s      = GNT_READ;
      win_addr_s = da_in;
    end else if (ia_enable) begin
      win_s      = GNT_FETCH;
      win_addr_s = ia;
    end else begin
      win_s      = GNT_NONE;
      win_addr_s = {WIDTH{1'b0}};
    end
  end

  // Fetch starvation count: grows each time fetch waits while another requester wins.
  always_comb begin
    starve_nxt_s = starve_r;
    if (state_r == ST_IDLE) begin
      if (!ia_enable || (win_s == GNT_FETCH)) begin
        starve_nxt_s = {SW{1'b0}};
      end else if (starve_r != STARVE_MAX) begin
        starve_nxt_s = starve_r + SW'(1);
      end else begin
        starve_nxt_s = starve_r;
      end
    end else begin
      starve_nxt_s = starve_r;
    end
  end

  // Completion of the current access: acknowledged or timed out.
  always_comb begin
    ack_s    = 1'b0;
    expire_s = 1'b0;
    if (state_r == ST_ACCESS) begin
      ack_s    = mem_ack;
      expire_s = !mem_ack && (wait_r == WAIT_LAST);
    end else begin
      ack_s    = 1'b0;
      expire_s = 1'b0;
    end
    done_s  = ack_s || expire_s;
    rdata_s = ack_s ? mem_rdata : {WIDTH{1'b0}};
  end

  // Transaction state machine.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_s != GNT_NONE) begin
            state_r <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (done_s) begin
            state_r <= ST_RELEASE;
          end
        end
        ST_RELEASE: state_r <= ST_IDLE;
        default:    state_r <= ST_IDLE;
      endcase
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_r <= {SW{1'b0}};
    end else begin
      starve_r <= starve_nxt_s;
    end
  end

  // Counts ACCESS cycles spent waiting on mem_ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_r <= {WW{1'b0}};
    end else if ((state_r == ST_ACCESS) && !done_s) begin
      wait_r <= wait_r + WW'(1);
    end else begin
      wait_r <= {WW{1'b0}};
    end
  end

  // Grant, latched address/data and memory strobes for the owning requester.
  always_ff @(posedge clock) begin
    if (reset) begin
      grant       <= GNT_NONE;
      mem_address <= {WIDTH{1'b0}};
      mem_wdata   <= {WIDTH{1'b0}};
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_s != GNT_NONE) begin
            grant       <= win_s;
            mem_address <= win_addr_s;
            mem_read    <= (win_s != GNT_WRITE);
            mem_write   <= (win_s == GNT_WRITE);
            if (win_s == GNT_WRITE) begin
              mem_wdata <= dv_out;
            end
          end
        end
        ST_ACCESS: begin
          if (done_s) begin
            grant     <= GNT_NONE;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end
        end
        ST_RELEASE: begin
          grant     <= GNT_NONE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
        default: begin
          grant     <= GNT_NONE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // Completion pulses and returned read data; iv/dv_in hold between transactions.
  always_ff @(posedge clock) begin
    if (reset) begin
      iv           <= {WIDTH{1'b0}};
      dv_in        <= {WIDTH{1'b0}};
      iv_valid     <= 1'b0;
      dv_in_valid  <= 1'b0;
      dv_out_valid <= 1'b0;
    end else begin
      iv_valid     <= 1'b0;
      dv_in_valid  <= 1'b0;
      dv_out_valid <= 1'b0;
      if (done_s) begin
        case (grant)
          GNT_FETCH: begin
            iv       <= rdata_s;
            iv_valid <= 1'b1;
          end
          GNT_READ: begin
            dv_in       <= rdata_s;
            dv_in_valid <= 1'b1;
          end
          GNT_WRITE: dv_out_valid <= 1'b1;
          default: begin
          end
        endcase
      end
    end
  end

  // Sticky timeout flag, cleared only by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      bus_error <= 1'b0;
    end else if (expire_s) begin
      bus_error <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic compared against a transaction-level priority/starvation model.
module tb_mem_arbiter;
  localparam int WIDTH = 32;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT = 255;

  logic clock = 1'b0;
  logic reset;
  logic [31:0] ia, da_in, da_out, dv_out, mem_rdata;
  logic ia_enable, da_in_enable, da_out_enable, mem_ack;
  logic [31:0] iv, dv_in, mem_address, mem_wdata;
  logic iv_valid, dv_in_valid, dv_out_valid, mem_read, mem_write, bus_error;
  logic [2:0] grant;

  always #5 clock = ~clock;

  mem_arbiter #(.WIDTH(WIDTH), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .ia(ia), .ia_enable(ia_enable), .iv(iv), .iv_valid(iv_valid),
    .da_in(da_in), .da_in_enable(da_in_enable), .dv_in(dv_in), .dv_in_valid(dv_in_valid),
    .da_out(da_out), .da_out_enable(da_out_enable), .dv_out(dv_out), .dv_out_valid(dv_out_valid),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .grant(grant), .bus_error(bus_error)
  );

  int n_checks = 0;
  int n_fail = 0;

  // reference model state
  int starve_m;
  logic [31:0] exp_iv, exp_dv_in;
  logic err_m;

  // observations of the last transaction
  logic [2:0] obs_grant, obs_valid, obs_rel_grant;
  logic [31:0] obs_addr, obs_wdata, obs_iv, obs_dv_in, acked_data;
  logic [31:0] snap_ia, snap_da_in, snap_da_out, snap_dv_out;
  int obs_rd, obs_wr, obs_pulses;
  logic obs_unstable, obs_both, obs_rel_strobe, obs_err, obs_acked;

  function automatic logic [2:0] model_pick(input logic f, input logic r, input logic w);
    if (f && starve_m >= STARVE_LIMIT) return 3'b001;
    if (w) return 3'b100;
    if (r) return 3'b010;
    if (f) return 3'b001;
    return 3'b000;
  endfunction

  task automatic model_commit(input logic f, input logic [2:0] g, input logic acked, input logic [31:0] d);
    logic [31:0] v;
    v = acked ? d : 32'h0;
    if (!f || g == 3'b001) starve_m = 0;
    else if (starve_m < STARVE_LIMIT) starve_m = starve_m + 1;
    if (g == 3'b001) exp_iv = v;
    else if (g == 3'b010) exp_dv_in = v;
    if (!acked) err_m = 1'b1;
  endtask

  function automatic logic [31:0] sel_addr(input logic [2:0] g);
    if (g == 3'b001) return snap_ia;
    if (g == 3'b010) return snap_da_in;
    return snap_da_out;
  endfunction

  task automatic idle_cycles(input int n);
    ia_enable = 1'b0; da_in_enable = 1'b0; da_out_enable = 1'b0;
    repeat (n) begin
      @(posedge clock); #1;
    end
    starve_m = 0;
  endtask

  // Runs one transaction starting from an IDLE cycle; ack_cycle 0 means never ack.
  task automatic do_txn(input int ack_cycle, input logic use_fixed, input logic [31:0] fixed);
    int n_acc;
    n_acc = (ack_cycle >= 1 && ack_cycle <= TIMEOUT) ? ack_cycle : TIMEOUT;
    obs_acked = (ack_cycle >= 1 && ack_cycle <= TIMEOUT);
    obs_rd = 0; obs_wr = 0; obs_pulses = 0;
    obs_unstable = 1'b0; obs_both = 1'b0; acked_data = 32'h0;
    snap_ia = ia; snap_da_in = da_in; snap_da_out = da_out; snap_dv_out = dv_out;
    @(posedge clock); #1;
    obs_grant = grant; obs_addr = mem_address; obs_wdata = mem_wdata;
    for (int k = 1; k <= n_acc; k++) begin
      if (mem_read) obs_rd++;
      if (mem_write) obs_wr++;
      if (mem_read && mem_write) obs_both = 1'b1;
      if (grant !== obs_grant || mem_address !== obs_addr) obs_unstable = 1'b1;
      obs_pulses += $countones({iv_valid, dv_in_valid, dv_out_valid});
      ia = $urandom; da_in = $urandom; da_out = $urandom; dv_out = $urandom;
      mem_rdata = (use_fixed && k == ack_cycle) ? fixed : $urandom;
      mem_ack = (k == ack_cycle);
      if (k == ack_cycle) acked_data = mem_rdata;
      @(posedge clock); #1;
      mem_ack = 1'b0;
    end
    if (mem_read) obs_rd++;
    if (mem_write) obs_wr++;
    obs_pulses += $countones({iv_valid, dv_in_valid, dv_out_valid});
    obs_valid = {dv_out_valid, dv_in_valid, iv_valid};
    obs_iv = iv; obs_dv_in = dv_in; obs_rel_grant = grant;
    obs_rel_strobe = mem_read | mem_write; obs_err = bus_error;
    if (iv_valid) ia_enable = 1'b0;
    if (dv_in_valid) da_in_enable = 1'b0;
    if (dv_out_valid) da_out_enable = 1'b0;
    mem_ack = 1'b1;
    @(posedge clock); #1;
    mem_ack = 1'b0;
    if (mem_read) obs_rd++;
    if (mem_write) obs_wr++;
    obs_pulses += $countones({iv_valid, dv_in_valid, dv_out_valid});
  endtask

  task automatic test_reset;
    reset = 1'b1; mem_ack = 1'b0; mem_rdata = 32'h0;
    ia = 32'h0; da_in = 32'h0; da_out = 32'h0; dv_out = 32'h0;
    ia_enable = 1'b0; da_in_enable = 1'b0; da_out_enable = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++;
    if ({grant, mem_read, mem_write, bus_error} !== 6'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got grant=%b rd=%b wr=%b err=%b expected all 0", grant, mem_read, mem_write, bus_error);
    end
    n_checks++;
    if ({iv_valid, dv_in_valid, dv_out_valid} !== 3'b0) begin
      n_fail++; $display("FAIL reset_valid: got %b expected 000", {dv_out_valid, dv_in_valid, iv_valid});
    end
    n_checks++;
    if (iv !== 32'h0 || dv_in !== 32'h0 || mem_address !== 32'h0 || mem_wdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got iv=%h dv_in=%h addr=%h wdata=%h expected 0", iv, dv_in, mem_address, mem_wdata);
    end
    reset = 1'b0;
    starve_m = 0; exp_iv = 32'h0; exp_dv_in = 32'h0; err_m = 1'b0;
  endtask

  task automatic test_single_fetch;
    logic [2:0] g;
    ia = 32'h100; ia_enable = 1'b1;
    g = model_pick(1'b1, 1'b0, 1'b0);
    do_txn(2, 1'b1, 32'hDEADBEEF);
    model_commit(1'b1, g, obs_acked, acked_data);
    n_checks++;
    if (obs_grant !== 3'b001) begin
      n_fail++; $display("FAIL fetch_grant: got %b expected 001", obs_grant);
    end
    n_checks++;
    if (obs_rd != 2 || obs_wr != 0) begin
      n_fail++; $display("FAIL fetch_strobe: got rd=%0d wr=%0d expected rd=2 wr=0", obs_rd, obs_wr);
    end
    n_checks++;
    if (obs_iv !== 32'hDEADBEEF || obs_addr !== 32'h100) begin
      n_fail++; $display("FAIL fetch_data: got iv=%h addr=%h expected iv=deadbeef addr=100", obs_iv, obs_addr);
    end
    n_checks++;
    if (obs_valid !== 3'b001 || obs_pulses != 1) begin
      n_fail++; $display("FAIL fetch_valid: got valid=%b pulses=%0d expected 001 and 1", obs_valid, obs_pulses);
    end
  endtask

  task automatic test_priority;
    logic [2:0] g;
    logic [2:0] order [3];
    logic f;
    order[0] = 3'b100; order[1] = 3'b010; order[2] = 3'b001;
    ia = $urandom; da_in = $urandom; da_out = $urandom; dv_out = $urandom;
    ia_enable = 1'b1; da_in_enable = 1'b1; da_out_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      f = ia_enable;
      g = model_pick(ia_enable, da_in_enable, da_out_enable);
      do_txn(1, 1'b0, 32'h0);
      model_commit(f, g, obs_acked, acked_data);
      n_checks++;
      if (obs_grant !== order[i] || obs_grant !== g) begin
        n_fail++; $display("FAIL prio_grant[%0d]: got %b expected %b", i, obs_grant, order[i]);
      end
      n_checks++;
      if (obs_valid !== order[i] || obs_pulses != 1) begin
        n_fail++; $display("FAIL prio_valid[%0d]: got %b pulses=%0d expected %b and 1", i, obs_valid, obs_pulses, order[i]);
      end
      n_checks++;
      if (obs_addr !== sel_addr(g)) begin
        n_fail++; $display("FAIL prio_addr[%0d]: got %h expected %h", i, obs_addr, sel_addr(g));
      end
    end
  endtask

  task automatic test_starvation;
    logic [2:0] g;
    idle_cycles(1);
    ia = $urandom; ia_enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      da_out = $urandom; dv_out = $urandom; da_out_enable = 1'b1;
      da_in = $urandom; da_in_enable = 1'($urandom_range(0, 1));
      g = model_pick(1'b1, da_in_enable, 1'b1);
      do_txn($urandom_range(1, 3), 1'b0, 32'h0);
      model_commit(1'b1, g, obs_acked, acked_data);
      n_checks++;
      if (obs_grant !== g) begin
        n_fail++; $display("FAIL starve_grant[%0d]: got %b expected %b", i, obs_grant, g);
      end
      if (i == 4) begin
        n_checks++;
        if (obs_grant !== 3'b001 || obs_iv !== acked_data) begin
          n_fail++; $display("FAIL starve_fetch: got grant=%b iv=%h expected 001 iv=%h", obs_grant, obs_iv, acked_data);
        end
      end
    end
  endtask

  task automatic test_ack_outside;
    idle_cycles(1);
    mem_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      n_checks++;
      if ({iv_valid, dv_in_valid, dv_out_valid, mem_read, mem_write} !== 5'b0 || grant !== 3'b000) begin
        n_fail++; $display("FAIL ack_idle[%0d]: got valids=%b grant=%b rd=%b wr=%b expected all 0",
                           i, {dv_out_valid, dv_in_valid, iv_valid}, grant, mem_read, mem_write);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random;
    logic [2:0] g;
    logic f;
    int ack, n_exp;
    for (int t = 0; t < 40; t++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
      if (!ia_enable && $urandom_range(0, 1) == 1) begin ia = $urandom; ia_enable = 1'b1; end
      if (!da_in_enable && $urandom_range(0, 1) == 1) begin da_in = $urandom; da_in_enable = 1'b1; end
      if (!da_out_enable && $urandom_range(0, 2) == 0) begin
        da_out = $urandom; dv_out = $urandom; da_out_enable = 1'b1;
      end
      if (!ia_enable && !da_in_enable && !da_out_enable) begin ia = $urandom; ia_enable = 1'b1; end
      f = ia_enable;
      g = model_pick(ia_enable, da_in_enable, da_out_enable);
      ack = $urandom_range(1, 5);
      do_txn(ack, 1'b0, 32'h0);
      model_commit(f, g, obs_acked, acked_data);
      n_exp = ack;
      n_checks++;
      if (obs_grant !== g || obs_valid !== g || obs_pulses != 1) begin
        n_fail++; $display("FAIL rand_grant[%0d]: got grant=%b valid=%b pulses=%0d expected %b %b 1",
                           t, obs_grant, obs_valid, obs_pulses, g, g);
      end
      n_checks++;
      if (obs_rd != ((g == 3'b100) ? 0 : n_exp) || obs_wr != ((g == 3'b100) ? n_exp : 0)) begin
        n_fail++; $display("FAIL rand_strobe[%0d]: got rd=%0d wr=%0d expected %0d cycles on grant %b", t, obs_rd, obs_wr, n_exp, g);
      end
      n_checks++;
      if (obs_addr !== sel_addr(g)) begin
        n_fail++; $display("FAIL rand_addr[%0d]: got %h expected %h", t, obs_addr, sel_addr(g));
      end
      n_checks++;
      if (obs_iv !== exp_iv || obs_dv_in !== exp_dv_in) begin
        n_fail++; $display("FAIL rand_data[%0d]: got iv=%h dv_in=%h expected iv=%h dv_in=%h", t, obs_iv, obs_dv_in, exp_iv, exp_dv_in);
      end
      n_checks++;
      if (obs_rel_grant !== 3'b000 || obs_rel_strobe !== 1'b0 || obs_unstable || obs_both) begin
        n_fail++; $display("FAIL rand_release[%0d]: got grant=%b strobe=%b unstable=%b both=%b expected 000 0 0 0",
                           t, obs_rel_grant, obs_rel_strobe, obs_unstable, obs_both);
      end
      if (g == 3'b100) begin
        n_checks++;
        if (obs_wdata !== snap_dv_out) begin
          n_fail++; $display("FAIL rand_wdata[%0d]: got %h expected %h", t, obs_wdata, snap_dv_out);
        end
      end
    end
  endtask

  task automatic test_timeout;
    idle_cycles(1);
    da_in = $urandom; da_in_enable = 1'b1;
    do_txn(TIMEOUT, 1'b0, 32'h0);
    model_commit(1'b0, 3'b010, obs_acked, acked_data);
    n_checks++;
    if (obs_err !== 1'b0 || obs_dv_in !== exp_dv_in || obs_valid !== 3'b010 || obs_rd != TIMEOUT) begin
      n_fail++; $display("FAIL late_ack: got err=%b dv_in=%h valid=%b rd=%0d expected 0 %h 010 %0d",
                         obs_err, obs_dv_in, obs_valid, obs_rd, exp_dv_in, TIMEOUT);
    end
    da_in = $urandom; da_in_enable = 1'b1;
    do_txn(0, 1'b0, 32'h0);
    model_commit(1'b0, 3'b010, obs_acked, acked_data);
    n_checks++;
    if (obs_err !== 1'b1 || obs_dv_in !== 32'h0 || obs_valid !== 3'b010 || obs_pulses != 1 || obs_rd != TIMEOUT) begin
      n_fail++; $display("FAIL timeout: got err=%b dv_in=%h valid=%b pulses=%0d rd=%0d expected 1 0 010 1 %0d",
                         obs_err, obs_dv_in, obs_valid, obs_pulses, obs_rd, TIMEOUT);
    end
    ia = $urandom; ia_enable = 1'b1;
    do_txn(1, 1'b0, 32'h0);
    model_commit(1'b1, 3'b001, obs_acked, acked_data);
    idle_cycles(3);
    n_checks++;
    if (obs_err !== err_m || bus_error !== err_m || obs_iv !== exp_iv) begin
      n_fail++; $display("FAIL sticky_err: got err=%b/%b iv=%h expected %b iv=%h", obs_err, bus_error, obs_iv, err_m, exp_iv);
    end
  endtask

  task automatic test_reset_mid_access;
    int pulses;
    da_out = $urandom; dv_out = $urandom; da_out_enable = 1'b1;
    @(posedge clock); #1;
    n_checks++;
    if (mem_write !== 1'b1 || grant !== 3'b100) begin
      n_fail++; $display("FAIL mid_pre: got wr=%b grant=%b expected 1 100", mem_write, grant);
    end
    @(posedge clock); #1;
    reset = 1'b1; da_out_enable = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0;
    starve_m = 0; exp_iv = 32'h0; exp_dv_in = 32'h0; err_m = 1'b0;
    n_checks++;
    if (mem_write !== 1'b0 || grant !== 3'b000 || dv_out_valid !== 1'b0 || bus_error !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got wr=%b grant=%b dv_out_valid=%b err=%b expected 0 000 0 0",
                         mem_write, grant, dv_out_valid, bus_error);
    end
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
      if (dv_out_valid) pulses++;
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++; $display("FAIL mid_nopulse: got %0d pulses expected 0", pulses);
    end
    da_out = $urandom; dv_out = $urandom; da_out_enable = 1'b1;
    do_txn(1, 1'b0, 32'h0);
    model_commit(1'b0, 3'b100, obs_acked, acked_data);
    n_checks++;
    if (obs_valid !== 3'b100 || obs_wr != 1 || obs_wdata !== snap_dv_out || obs_addr !== snap_da_out || obs_iv !== exp_iv) begin
      n_fail++; $display("FAIL mid_fresh: got valid=%b wr=%0d wdata=%h addr=%h iv=%h expected 100 1 %h %h %h",
                         obs_valid, obs_wr, obs_wdata, obs_addr, obs_iv, snap_dv_out, snap_da_out, exp_iv);
    end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_priority();
    test_starvation();
    test_ack_outside();
    test_random();
    test_timeout();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32: width of every address and data bus.
REQ-002 Parameter STARVE_LIMIT, default 4: lost arbitrations after which fetch gets top priority.
REQ-003 Parameter TIMEOUT, default 255: max ACCESS cycles waiting for mem_ack.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 ia / ia_enable  in  WIDTH / 1  fetch request address / request.
REQ-007 iv / iv_valid  out  WIDTH / 1  fetch read data / one-cycle completion pulse.
REQ-008 da_in / da_in_enable  in  WIDTH / 1  data-read request address / request.
REQ-009 dv_in / dv_in_valid  out  WIDTH / 1  data-read data / one-cycle completion pulse.
REQ-010 da_out / da_out_enable / dv_out  in  WIDTH / 1 / WIDTH  data-write address / request / write data.
REQ-011 dv_out_valid  out  1  one-cycle write-completion pulse.
REQ-012 mem_address / mem_wdata  out  WIDTH  shared memory port address / write data.
REQ-013 mem_read / mem_write  out  1  memory strobes, held for the whole access.
REQ-014 mem_rdata / mem_ack  in  WIDTH / 1  memory read data / access done (single cycle).
REQ-015 grant  out  3  one-hot {write, read, fetch} owner of current access; 0 when none.
REQ-016 bus_error  out  1  sticky timeout flag.

Function
REQ-017 The block SHALL share one memory port among fetch, data-read and data-write requesters, one access at a time.
REQ-018 The FSM SHALL have states IDLE, ACCESS, RELEASE.
REQ-019 IDLE: if any enable high, latch winner's address (and dv_out for write) into registers, set grant, go ACCESS next cycle; else stay IDLE.
REQ-020 Priority SHALL be write > read > fetch, except fetch wins outright when starve_count == STARVE_LIMIT.
REQ-021 starve_count SHALL increment (saturating at STARVE_LIMIT) on each IDLE grant to write/read while ia_enable high; clear on fetch grant or when ia_enable low in IDLE.
REQ-022 ACCESS: mem_read (fetch/read) or mem_write (write) high, mem_address/mem_wdata from latched registers; requester inputs ignored.
REQ-023 On mem_ack in ACCESS: the granted requester's valid SHALL pulse high the next cycle; iv/dv_in SHALL carry mem_rdata registered at ack; FSM goes RELEASE.
REQ-024 RELEASE: lasts exactly one cycle, strobes low, grant 0, valid pulse visible, no new grant; then IDLE.
REQ-025 Requesters SHALL drop enable in the cycle valid is high; an enable still high in the following IDLE SHALL be treated as a new request.
REQ-026 Minimum transaction spacing SHALL be 3 cycles (IDLE, ACCESS with immediate ack, RELEASE).
REQ-027 A wait counter SHALL count ACCESS cycles; if it reaches TIMEOUT without mem_ack: set bus_error, return data 0 with the normal valid pulse, go RELEASE.
REQ-028 mem_ack arriving in the same cycle as the counter reaching TIMEOUT SHALL count as success (no error).
REQ-029 mem_ack outside ACCESS SHALL be ignored.
REQ-030 Only one of iv_valid, dv_in_valid, dv_out_valid SHALL be high in any cycle; mem_read and mem_write never both high.
REQ-031 iv and dv_in SHALL hold their last value between transactions.

Reset
REQ-032 reset high at a clock edge SHALL force IDLE, grant 0, all strobes and valids 0, iv/dv_in 0, mem_address/mem_wdata 0, starve_count 0, wait counter 0, bus_error 0, aborting any in-flight access with no valid pulse.
REQ-033 bus_error SHALL clear only on reset.

Verification
REQ-034 Single fetch: ia=0x100, ia_enable=1, mem_ack 2 cycles into ACCESS with mem_rdata=0xDEADBEEF -> mem_read high 2 cycles, iv=0xDEADBEEF, one iv_valid pulse, grant=001 during ACCESS.
REQ-035 Simultaneous requests all three, immediate ack -> grant order 100, 010, 001 across three transactions; each valid pulses once.
REQ-036 Fetch starvation: ia_enable held, write/read re-requested continuously -> fetch granted on the 5th arbitration (STARVE_LIMIT=4) despite pending write.
REQ-037 No mem_ack, TIMEOUT=255 -> valid pulse with data 0 after 255 ACCESS cycles, bus_error=1 and stays 1 until reset.
REQ-038 reset asserted mid-ACCESS of a write -> next cycle mem_write=0, grant=0, no dv_out_valid; a later fresh request completes normally.
